// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and main/video memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic [1:0]  m0_wr;
  logic [1:0]  m1_wr;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic        vm_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        gnt_id;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    output m0_ack, m1_ack, rdata, mem_addr, mem_wdata, mem_read, mem_write, vm_write, busy, gnt_id
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    input  m0_ack, m1_ack, rdata, mem_addr, mem_wdata, mem_read, mem_write, vm_write, busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) memory arbiter with video-memory write decode; ARB_ROUND_ROBIN_EN selects round-robin tie-break.
// Latency: request sampled in IDLE -> MEM_LAT BUSY cycles -> one ACK cycle (one transaction per MEM_LAT+2 cycles).
// Backpressure: requesters hold req until their ack; a new request is only taken in IDLE.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_wr;
  logic        gnt_id_q;
  logic [31:0] rdata_q;
  logic        any_req;
  logic        sel;
  logic        take;
  logic        done;

  assign any_req = bus.m0_req | bus.m1_req;
  assign take    = (state == IDLE) && any_req;
  assign done    = (state == BUSY) && (cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  // last_gnt resets to 1 so the first tie after reset goes to port 0
  logic last_gnt;

  assign sel = (bus.m0_req && bus.m1_req) ? ~last_gnt : bus.m1_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else if (take) begin
      last_gnt <= sel;
    end
  end
`else
  assign sel = ~bus.m0_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_wr    <= 2'b00;
      gnt_id_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      if (take) begin
        gnt_id_q  <= sel;
        lat_addr  <= sel ? bus.m1_addr  : bus.m0_addr;
        lat_wdata <= sel ? bus.m1_wdata : bus.m0_wdata;
        lat_wr    <= sel ? bus.m1_wr    : bus.m0_wr;
        cnt       <= 4'(MEM_LAT - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (done && (lat_wr == 2'b00)) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.gnt_id = gnt_id_q;

  always_comb begin
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 2'b00;
    bus.vm_write  = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      BUSY: begin
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        if (lat_wr == 2'b00) begin
          bus.mem_read = 1'b1;
        end else if (lat_addr[31:28] == 4'hA) begin
          // 0xA region is video memory: only its single strobe fires
          bus.vm_write = lat_wr[0];
        end else begin
          bus.mem_write = lat_wr;
        end
      end
      ACK: begin
        bus.m0_ack = ~gnt_id_q;
        bus.m1_ack = gnt_id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=2).
module tb_mem_arbiter;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.m0_req = 1'b0;  bus.m1_req = 1'b0;
    bus.m0_wr = 2'b00;  bus.m1_wr = 2'b00;
    bus.m0_addr = '0;   bus.m1_addr = '0;
    bus.m0_wdata = '0;  bus.m1_wdata = '0;
  endtask

  task automatic drive_port(input bit port, input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      bus.m0_req = 1'b1; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = 1'b1; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mem_rdata = 32'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.gnt_id !== 1'b0) begin errors++; $display("FAIL reset_state: busy=%0b gnt_id=%0b want 0/0", bus.busy, bus.gnt_id); end
    checks++; if (bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h want 0", bus.rdata, bus.mem_addr, bus.mem_wdata); end
    checks++; if ({bus.mem_read, bus.mem_write, bus.vm_write, bus.m0_ack, bus.m1_ack} !== 6'b0) begin errors++; $display("FAIL reset_strobes: rd=%0b wr=%b vm=%0b ack0=%0b ack1=%0b want 0", bus.mem_read, bus.mem_write, bus.vm_write, bus.m0_ack, bus.m1_ack); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy=%0b mem_read=%0b want 0/0", bus.busy, bus.mem_read); end
  endtask

  task automatic test_read();
    @(negedge clk);
    bus.mem_rdata = 32'h1234_5678;
    drive_port(1'b0, 2'b00, 32'h0000_0010, 32'h0);
    for (int i = 0; i < MEM_LAT; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h10 || bus.busy !== 1'b1) begin errors++; $display("FAIL read_busy%0d: mem_read=%0b mem_addr=%h busy=%0b want 1/00000010/1", i, bus.mem_read, bus.mem_addr, bus.busy); end
      checks++; if (bus.m0_ack !== 1'b0 || bus.gnt_id !== 1'b0) begin errors++; $display("FAIL read_noack%0d: m0_ack=%0b gnt_id=%0b want 0/0", i, bus.m0_ack, bus.gnt_id); end
    end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL read_ack: m0_ack=%0b m1_ack=%0b mem_read=%0b want 1/0/0", bus.m0_ack, bus.m1_ack, bus.mem_read); end
    checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata: got %h want 12345678", bus.rdata); end
    bus.m0_req = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_after: m0_ack=%0b busy=%0b rdata=%h want 0/0/12345678", bus.m0_ack, bus.busy, bus.rdata); end
  endtask

  task automatic test_vm_write();
    @(negedge clk);
    bus.mem_rdata = 32'h0BAD_F00D;
    drive_port(1'b1, 2'b11, 32'hA000_0040, 32'h0000_00FF);
    for (int i = 0; i < MEM_LAT; i++) begin
      @(negedge clk);
      checks++; if (bus.vm_write !== 1'b1 || bus.mem_write !== 2'b00 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL vm_busy%0d: vm_write=%0b mem_write=%b mem_read=%0b want 1/00/0", i, bus.vm_write, bus.mem_write, bus.mem_read); end
      checks++; if (bus.mem_wdata !== 32'hFF || bus.gnt_id !== 1'b1 || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL vm_data%0d: mem_wdata=%h gnt_id=%0b m1_ack=%0b want 000000ff/1/0", i, bus.mem_wdata, bus.gnt_id, bus.m1_ack); end
    end
    @(negedge clk);
    checks++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0 || bus.vm_write !== 1'b0) begin errors++; $display("FAIL vm_ack: m1_ack=%0b m0_ack=%0b vm_write=%0b want 1/0/0", bus.m1_ack, bus.m0_ack, bus.vm_write); end
    checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL vm_rdata_hold: got %h want 12345678", bus.rdata); end
    bus.m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mem_write();
    @(negedge clk);
    drive_port(1'b0, 2'b01, 32'h0000_0100, 32'hA5A5_0001);
    for (int i = 0; i < MEM_LAT; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_write !== 2'b01 || bus.vm_write !== 1'b0 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL mw_busy%0d: mem_write=%b vm_write=%0b mem_addr=%h want 01/0/00000100", i, bus.mem_write, bus.vm_write, bus.mem_addr); end
    end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1 || bus.mem_write !== 2'b00) begin errors++; $display("FAIL mw_ack: m0_ack=%0b mem_write=%b want 1/00", bus.m0_ack, bus.mem_write); end
    bus.m0_req = 1'b0;
    @(negedge clk);
    // video region with wr[0]=0: neither strobe fires
    drive_port(1'b0, 2'b10, 32'hA000_0000, 32'h1);
    @(negedge clk);
    checks++; if (bus.vm_write !== 1'b0 || bus.mem_write !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL vm_wr10: vm_write=%0b mem_write=%b busy=%0b want 0/00/1", bus.vm_write, bus.mem_write, bus.busy); end
    repeat (MEM_LAT) @(negedge clk);
    bus.m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    @(negedge clk);
    drive_port(1'b0, 2'b00, 32'h0000_0020, 32'h0);
    @(negedge clk);
    bus.m0_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL drop_busy: busy=%0b mem_read=%0b want 1/1", bus.busy, bus.mem_read); end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b1) begin errors++; $display("FAIL drop_ack: m0_ack=%0b want 1", bus.m0_ack); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.m0_ack !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%0b m0_ack=%0b want 0/0", bus.busy, bus.m0_ack); end
  endtask

  task automatic test_arbitration();
    int n = 0;
    int ack_port[4];
    int ack_cyc[4];
    int exp_port;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_port(1'b0, 2'b00, 32'h0000_0030, 32'h0);
    drive_port(1'b1, 2'b00, 32'h0000_0040, 32'h0);
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) begin
        ack_port[n] = bus.m1_ack ? 1 : 0;
        ack_cyc[n]  = c;
        n++;
        if (n == 4) begin
          bus.m0_req = 1'b0;
          bus.m1_req = 1'b0;
        end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL arb_timeout: acks=%0d want 4", n); end
    if (n > 0) begin
      checks++; if (ack_cyc[0] != MEM_LAT) begin errors++; $display("FAIL arb_first_lat: ack at %0d want %0d", ack_cyc[0], MEM_LAT); end
    end
    for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      checks++; if (ack_port[i] != exp_port) begin errors++; $display("FAIL arb_grant%0d: port=%0d want %0d", i, ack_port[i], exp_port); end
      if (i > 0) begin
        checks++; if (ack_cyc[i] - ack_cyc[i-1] != MEM_LAT + 2) begin errors++; $display("FAIL arb_spacing%0d: %0d cycles want %0d", i, ack_cyc[i] - ack_cyc[i-1], MEM_LAT + 2); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_port(1'b1, 2'b11, 32'h0000_0200, 32'h55);
    @(negedge clk);
    checks++; if (bus.mem_write !== 2'b11 || bus.gnt_id !== 1'b1) begin errors++; $display("FAIL rmid_busy1: mem_write=%b gnt_id=%0b want 11/1", bus.mem_write, bus.gnt_id); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_write !== 2'b00 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rmid_outputs: busy=%0b mem_write=%b mem_addr=%h mem_wdata=%h want 0", bus.busy, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.gnt_id !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rmid_regs: gnt_id=%0b rdata=%h want 0/0", bus.gnt_id, bus.rdata); end
    @(negedge clk);
    checks++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_noack: m0_ack=%0b m1_ack=%0b busy=%0b want 0/0/0", bus.m0_ack, bus.m1_ack, bus.busy); end
    rst = 1'b1;
    bus.mem_rdata = 32'hCAFE_BABE;
    drive_port(1'b1, 2'b00, 32'h0000_0300, 32'h0);
    for (int i = 0; i < MEM_LAT; i++) begin
      @(negedge clk);
      checks++; if (bus.gnt_id !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h300) begin errors++; $display("FAIL rmid_m1_busy%0d: gnt_id=%0b mem_read=%0b mem_addr=%h want 1/1/00000300", i, bus.gnt_id, bus.mem_read, bus.mem_addr); end
    end
    @(negedge clk);
    checks++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0 || bus.rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL rmid_m1_ack: m1_ack=%0b m0_ack=%0b rdata=%h want 1/0/cafebabe", bus.m1_ack, bus.m0_ack, bus.rdata); end
    bus.m1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_vm_write();
    test_mem_write();
    test_drop();
    test_arbitration();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access cycles per transaction (legal 1..15).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 m0_req, m1_req  input  1 each  requester 0 (CPU) / 1 (DMA) access request; held until the matching ack.
REQ-005 m0_wr, m1_wr  input  2 each  write enables; 2'b00 = read.
REQ-006 m0_addr, m1_addr  input  32 each  byte address.
REQ-007 m0_wdata, m1_wdata  input  32 each  write data.
REQ-008 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-009 rdata  output  32  read data shared by both requesters; valid with ack.
REQ-010 mem_addr, mem_wdata  output  32 each  to main memory and video memory.
REQ-011 mem_read  output  1; mem_write  output  2; vm_write  output  1 (video memory write strobe).
REQ-012 mem_rdata  input  32  main memory read data.
REQ-013 busy  output  1  high while in BUSY or ACK; gnt_id  output  1  port owning the current transaction.

Function
REQ-014 States: IDLE, BUSY, ACK; exactly one transaction in flight.
REQ-015 IDLE with no request: all mem_* outputs, vm_write and acks SHALL be 0.
REQ-016 IDLE with any request: select a port (REQ-022), latch its addr/wr/wdata, set gnt_id, enter BUSY.
REQ-017 BUSY lasts exactly MEM_LAT cycles, counted by a 4-bit down-counter; mem_addr/mem_wdata driven from latched values throughout.
REQ-018 During BUSY, read (wr==0): mem_read=1; rdata captured from mem_rdata on the final BUSY cycle.
REQ-019 During BUSY, write with addr[31:28]==4'hA: mem_write=0, vm_write=wr[0]; any other write: mem_write=wr, vm_write=0.
REQ-020 ACK: exactly one cycle, the granted port's ack=1, then IDLE; rdata holds its last captured value until the next read capture.
REQ-021 Latency: request sampled in IDLE at edge T gives ack high during cycle T+1+MEM_LAT; back-to-back throughput is one transaction per MEM_LAT+2 cycles.
REQ-022 Arbitration: a single request wins; simultaneous requests are resolved per REQ-027.
REQ-023 A request dropped during BUSY SHALL NOT abort the transaction; ack is still issued.
REQ-024 A request still high in the IDLE cycle after its ack is treated as a new request.

Reset
REQ-025 While rst=0: state=IDLE, counter=0, all outputs 0 (rdata=0, gnt_id=0), priority pointer at "last granted = port 1".
REQ-026 Reset asserted mid-transaction aborts it immediately with no ack; the first post-reset arbitration follows REQ-025.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to the port not granted last and the pointer updates on every grant; when undefined, port 0 always wins and the pointer is absent.

Verification
REQ-028 MEM_LAT=2, m0 read 0x0000_0010, mem_rdata=0x1234_5678 -> mem_read high 2 cycles, m0_ack 3 cycles after the request edge, rdata=0x1234_5678.
REQ-029 m1 write wr=2'b11, addr 0xA000_0040, wdata 0xFF -> vm_write=1 and mem_write=0 for 2 cycles, then m1_ack.
REQ-030 m0 write wr=2'b01, addr 0x0000_0100 -> mem_write=2'b01 and vm_write=0 for 2 cycles, then m0_ack.
REQ-031 Both ports request continuously with ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1; without the macro -> port 0 only.
REQ-032 m0 drops its request in the first BUSY cycle -> the transaction completes and m0_ack still pulses.
REQ-033 rst low in the second BUSY cycle -> all outputs 0 at once, no ack; after release, an m1-only request is granted normally.
